// File: rtl/apbuart_pkg.sv
// apbuart_pkg: shared definitions for the apbuart_host APB initiator.
//   - UART register offsets relative to the UART base address
//   - status register bit positions
//   - host FSM state encoding
//   - scaler_val(): elaboration-time baud scaler computation
package apbuart_pkg;

  localparam logic [31:0] UART_DATA = 32'h0000_0000;
  localparam logic [31:0] UART_STAT = 32'h0000_0004;
  localparam logic [31:0] UART_CTRL = 32'h0000_0008;
  localparam logic [31:0] UART_SCL  = 32'h0000_000C;

  localparam int DR = 0;
  localparam int OV = 4;
  localparam int PE = 5;
  localparam int FE = 6;
  localparam int TF = 9;

  typedef enum logic [2:0] {
    CFG_CTRL,
    CFG_SCL,
    IDLE,
    POLL,
    RD_DATA,
    WR_DATA,
    GAP
  } state_e;

  // UART runs 8 scaler ticks per bit; integer division truncates.
  function automatic logic [31:0] scaler_val(input int clk_freq, input int baud);
    return 32'(clk_freq / (baud * 8) - 1);
  endfunction

endpackage

// File: rtl/apb_master_port.sv
// apb_master_port: single-transfer APB engine.
//   i_req/i_addr/i_wr/i_wdata : transfer request, sampled when the port is idle
//   o_done                    : high in the completing ACCESS cycle
//   o_rdata/o_err             : read data / pslverr, valid with o_done
//   psel..pwdata              : APB request outputs (all registered)
//   prdata/pready/pslverr     : APB response inputs
// After every completion the port spends one cycle idle, so back-to-back
// requests are always separated by at least one idle bus cycle.
module apb_master_port (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_psel,
  output logic        o_penable,
  output logic [31:0] o_paddr,
  output logic        o_pwrite,
  output logic [31:0] o_pwdata,
  input  logic [31:0] i_prdata,
  input  logic        i_pready,
  input  logic        i_pslverr
);

  logic        r_psel, r_penable, r_pwrite;
  logic [31:0] r_paddr, r_pwdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else if (r_psel && r_penable && i_pready) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else if (r_psel) begin
      r_penable <= 1'b1;
    end else if (i_req) begin
      // address/data captured once so they stay stable through wait states
      r_psel    <= 1'b1;
      r_paddr   <= i_addr;
      r_pwrite  <= i_wr;
      r_pwdata  <= i_wdata;
    end
  end

  assign o_done    = r_psel & r_penable & i_pready;
  assign o_rdata   = i_prdata;
  assign o_err     = o_done & i_pslverr;
  assign o_psel    = r_psel;
  assign o_penable = r_penable;
  assign o_paddr   = r_paddr;
  assign o_pwrite  = r_pwrite;
  assign o_pwdata  = r_pwdata;

endmodule

// File: rtl/apbuart_host.sv
// apbuart_host: APB initiator that configures and services one apbuart.
//   clk/rstn              : clock, async active-low reset
//   psel..pslverr         : APB initiator port
//   tx_valid/tx_data/tx_ready : TX byte stream in
//   rx_valid/rx_data/rx_ready : RX byte stream out
//   cfg_done              : ctrl and scaler written
//   bus_err               : sticky, any pslverr seen
//   line_err[2:0]         : sticky {FE,PE,OV}, only with APBUART_HOST_ERR_EN
// Optional feature macro: APBUART_HOST_ERR_EN.
module apbuart_host
  import apbuart_pkg::*;
#(
  parameter int          CLK_FREQ   = 50000000,
  parameter int          BAUD       = 9600,
  parameter logic [31:0] CTRL_INIT  = 32'h0000_0003,
  parameter logic [31:0] PADDR_BASE = 32'h0000_0000,
  parameter int          POLL_GAP   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        psel,
  output logic        penable,
  output logic [31:0] paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        cfg_done,
  output logic        bus_err
`ifdef APBUART_HOST_ERR_EN
  ,output logic [2:0] line_err
`endif
);

  localparam logic [31:0] SCALER = scaler_val(CLK_FREQ, BAUD);
  localparam int          GW     = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_e      r_state, w_next;
  logic        r_polled, r_dr, r_tf;
  logic [GW-1:0] r_gap;
  logic        r_rx_valid, r_cfg_done, r_bus_err;
  logic [7:0]  r_rx_data;
  logic        w_req, w_wr, w_done, w_err, w_gap_end;
  logic [31:0] w_addr, w_wdata, w_rdata;
  logic        w_unused;

  apb_master_port u_port (
    .clk       (clk),
    .rstn      (rstn),
    .i_req     (w_req),
    .i_addr    (w_addr),
    .i_wr      (w_wr),
    .i_wdata   (w_wdata),
    .o_done    (w_done),
    .o_rdata   (w_rdata),
    .o_err     (w_err),
    .o_psel    (psel),
    .o_penable (penable),
    .o_paddr   (paddr),
    .o_pwrite  (pwrite),
    .o_pwdata  (pwdata),
    .i_prdata  (prdata),
    .i_pready  (pready),
    .i_pslverr (pslverr)
  );

  assign w_gap_end = (POLL_GAP <= 1) || (r_gap == GW'(POLL_GAP - 1));
  assign w_unused  = ^w_rdata;

  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_addr  = PADDR_BASE + UART_STAT;
    w_wr    = 1'b0;
    w_wdata = '0;
    case (r_state)
      CFG_CTRL: begin
        w_req   = 1'b1;
        w_addr  = PADDR_BASE + UART_CTRL;
        w_wr    = 1'b1;
        w_wdata = CTRL_INIT;
        if (w_done) w_next = CFG_SCL;
      end
      CFG_SCL: begin
        w_req   = 1'b1;
        w_addr  = PADDR_BASE + UART_SCL;
        w_wr    = 1'b1;
        w_wdata = SCALER;
        if (w_done) w_next = IDLE;
      end
      IDLE: w_next = POLL;
      POLL: begin
        // the cycle after a clean poll is the decision cycle (no request)
        w_req = !r_polled;
        if (r_polled) begin
          if (r_dr && !r_rx_valid)      w_next = RD_DATA;
          else if (tx_valid && !r_tf)   w_next = WR_DATA;
          else                          w_next = GAP;
        end else if (w_err) begin
          w_next = GAP;
        end
      end
      RD_DATA: begin
        w_req  = 1'b1;
        w_addr = PADDR_BASE + UART_DATA;
        if (w_done) w_next = GAP;
      end
      WR_DATA: begin
        w_req   = 1'b1;
        w_addr  = PADDR_BASE + UART_DATA;
        w_wr    = 1'b1;
        w_wdata = {24'b0, tx_data};
        if (w_done) w_next = GAP;
      end
      GAP:     if (w_gap_end) w_next = IDLE;
      default: w_next = CFG_CTRL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= CFG_CTRL;
      r_polled   <= 1'b0;
      r_dr       <= 1'b0;
      r_tf       <= 1'b0;
      r_gap      <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_cfg_done <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state != POLL || r_polled) r_polled <= 1'b0;
      else if (w_done && !w_err)       r_polled <= 1'b1;
      // a poll answered with pslverr leaves the latched status untouched
      if (r_state == POLL && w_done && !w_err) begin
        r_dr <= w_rdata[DR];
        r_tf <= w_rdata[TF];
      end
      r_gap <= (r_state == GAP) ? r_gap + 1'b1 : '0;
      if (r_state == RD_DATA && w_done && !w_err) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= w_rdata[7:0];
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (r_state == CFG_SCL && w_done) r_cfg_done <= 1'b1;
      if (w_err)                        r_bus_err  <= 1'b1;
    end
  end

`ifdef APBUART_HOST_ERR_EN
  logic [2:0] r_line_err;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_line_err <= '0;
    else if (r_state == POLL && w_done && !w_err)
      r_line_err <= r_line_err | {w_rdata[FE], w_rdata[PE], w_rdata[OV]};
  end
  assign line_err = r_line_err;
`endif

  // the byte is consumed only on the completing ACCESS cycle of the write
  assign tx_ready = (r_state == WR_DATA) & w_done;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign cfg_done = r_cfg_done;
  assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_apbuart_host.sv
// tb_apbuart_host: self-checking bench for apbuart_host with a behavioural
// apbuart slave (loopback TX->RX, programmable wait states, TF and pslverr
// injection) and queue-based expected-data model.
module tb_apbuart_host;

  logic        clk, rstn;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, cfg_done, bus_err;
  logic [7:0]  tx_data, rx_data;
`ifdef APBUART_HOST_ERR_EN
  logic [2:0]  line_err;
`endif

  apbuart_host dut (
    .clk(clk), .rstn(rstn),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .cfg_done(cfg_done), .bus_err(bus_err)
`ifdef APBUART_HOST_ERR_EN
    , .line_err(line_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural UART slave ----------------
  typedef struct packed {logic [31:0] addr; logic wr; logic [31:0] data;} xfer_t;
  xfer_t       log_q[$];
  logic [7:0]  rxq[$];
  logic [7:0]  got_q[$];
  int          n_wait_cfg = 0;
  bit          rand_wait = 0, tf = 0, err_poll = 0;
  int          wcnt, cur_wait, len;
  bit          stable;
  logic [31:0] s_addr, s_wdata;
  logic        s_wr;

  initial begin pready = 0; pslverr = 0; prdata = 0; end

  always @(posedge clk) begin
    #1;
    if (psel && !penable) begin
      s_addr = paddr; s_wdata = pwdata; s_wr = pwrite;
      len = 1; wcnt = 0; stable = 1;
      cur_wait = rand_wait ? int'($urandom_range(0, 3)) : n_wait_cfg;
      pready = 0; pslverr = 0;
    end else if (psel && penable) begin
      len++;
      if (paddr !== s_addr || pwdata !== s_wdata || pwrite !== s_wr) stable = 0;
      if (wcnt == cur_wait) begin
        pready = 1; pslverr = 0; prdata = 0;
        chk("xfer_len", len, cur_wait + 2);
        chk("xfer_stable", stable, 1);
        if (pwrite) begin
          if (paddr == 32'h0) rxq.push_back(pwdata[7:0]);
        end else if (paddr == 32'h4) begin
          if (err_poll) begin pslverr = 1; prdata = '1; err_poll = 0; end
          else prdata = {22'b0, tf, 8'b0, rxq.size() != 0};
        end else if (paddr == 32'h0) begin
          prdata = (rxq.size() != 0) ? {24'b0, rxq.pop_front()} : 32'hEE;
        end
        log_q.push_back('{paddr, pwrite, pwrite ? pwdata : prdata});
      end else begin
        pready = 0; wcnt++;
      end
    end else begin
      pready = 0; pslverr = 0;
    end
  end

  always @(negedge clk)
    if (rstn && rx_valid && rx_ready) got_q.push_back(rx_data);

  // ---------------- helpers ----------------
  function automatic int n_data(input bit wr);
    int c = 0;
    foreach (log_q[i]) if (log_q[i].addr == 32'h0 && log_q[i].wr == wr) c++;
    return c;
  endfunction

  task automatic send(input logic [7:0] b, output bit ok);
    @(negedge clk); tx_valid = 1; tx_data = b; ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    tx_valid = 0;
  endtask

  task automatic wait_got(input int n, input string nm);
    for (int i = 0; i < 4000 && got_q.size() < n; i++) @(negedge clk);
    chk(nm, got_q.size() >= n, 1);
  endtask

  task automatic wait_cfg(input string nm);
    for (int i = 0; i < 300 && !cfg_done; i++) @(negedge clk);
    chk(nm, cfg_done, 1);
  endtask

  task automatic set_rx_ready(input logic v);
    @(posedge clk); #1; rx_ready = v;
  endtask

  typedef struct {logic [7:0] tx; int waits; logic [7:0] exp;} vec_t;
  vec_t       tbl[5];
  logic [7:0] exp_q[$];

  initial begin
    bit ok;
    int base, seen;
    logic [7:0] b, r0;

    tbl[0] = '{8'h2A, 0, 8'h2A};
    tbl[1] = '{8'hD5, 0, 8'hD5};
    tbl[2] = '{8'h00, 3, 8'h00};
    tbl[3] = '{8'hFF, 1, 8'hFF};
    tbl[4] = '{8'h5A, 3, 8'h5A};

    rstn = 0; tx_valid = 0; tx_data = 0; rx_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_psel", psel, 0);       chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);   chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);   chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0); chk("rst_rx_data", rx_data, 0);
    chk("rst_cfg_done", cfg_done, 0); chk("rst_bus_err", bus_err, 0);

    // configuration sequence
    rstn = 1;
    wait_cfg("cfg_timeout");
    chk("cfg_nxfer", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("cfg0_addr", log_q[0].addr, 32'h8); chk("cfg0_wr", log_q[0].wr, 1);
      chk("cfg0_data", log_q[0].data, 32'h3);
      chk("cfg1_addr", log_q[1].addr, 32'hC); chk("cfg1_wr", log_q[1].wr, 1);
      chk("cfg1_data", log_q[1].data, 32'd650);
    end

    // table-driven loopback, including wait-state entries
    log_q.delete();
    for (int i = 0; i < 5; i++) begin
      n_wait_cfg = tbl[i].waits;
      send(tbl[i].tx, ok);
      chk("tbl_accept", ok, 1);
      wait_got(i + 1, "tbl_timeout");
      if (got_q.size() > i) chk("tbl_rx", got_q[i], tbl[i].exp);
      if (i == 1) begin
        chk("tbl_nwr", n_data(1), 2);
        chk("tbl_nrd", n_data(0), 2);
      end
    end
    n_wait_cfg = 0;

    // randomized bytes and wait states against a FIFO model
    base = got_q.size();
    rand_wait = 1;
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send(b, ok);
      chk("rnd_accept", ok, 1);
    end
    wait_got(base + 16, "rnd_timeout");
    for (int k = 0; k < 16; k++)
      if (got_q.size() > base + k) chk("rnd_rx", got_q[base + k], exp_q[k]);
    rand_wait = 0;

    // consumer stall: first byte held, second not read
    base = got_q.size();
    set_rx_ready(0);
    log_q.delete();
    send(8'h11, ok); chk("stall_acc0", ok, 1);
    send(8'h22, ok); chk("stall_acc1", ok, 1);
    repeat (150) @(negedge clk);
    chk("stall_rx_valid", rx_valid, 1);
    chk("stall_rx_data", rx_data, 8'h11);
    chk("stall_nrd", n_data(0), 1);
    chk("stall_none_taken", got_q.size(), base);
    set_rx_ready(1);
    wait_got(base + 2, "stall_timeout");
    if (got_q.size() >= base + 2) begin
      chk("stall_rx0", got_q[base], 8'h11);
      chk("stall_rx1", got_q[base + 1], 8'h22);
    end

    // TX FIFO full blocks writes
    base = got_q.size();
    tf = 1; log_q.delete();
    @(negedge clk); tx_valid = 1; tx_data = 8'h3C; seen = 0;
    repeat (150) begin @(negedge clk); if (tx_ready) seen++; end
    chk("tf_tx_ready", seen, 0);
    chk("tf_nwr", n_data(1), 0);
    tf = 0; log_q.delete(); ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    tx_valid = 0;
    chk("tf_release", ok, 1);
    if (log_q.size() >= 2) begin
      chk("tf_first_poll", {log_q[0].addr[3:0], 3'b0, log_q[0].wr}, 8'h40);
      chk("tf_then_write", {log_q[1].addr[3:0], 3'b0, log_q[1].wr}, 8'h01);
    end else chk("tf_log", log_q.size(), 2);
    wait_got(base + 1, "tf_rx_timeout");
    if (got_q.size() > base) chk("tf_rx", got_q[base], 8'h3C);

    // pslverr on one poll
    repeat (30) @(negedge clk);
    r0 = rx_data;
    log_q.delete(); err_poll = 1;
    for (int i = 0; i < 200 && err_poll; i++) @(negedge clk);
    chk("err_injected", err_poll, 0);
    repeat (40) @(negedge clk);
    chk("err_bus_err", bus_err, 1);
    chk("err_rx_data", rx_data, r0);
    chk("err_nrd", n_data(0), 0);
    base = got_q.size();
    send(8'h77, ok); chk("err_acc", ok, 1);
    wait_got(base + 1, "err_rx_timeout");
    if (got_q.size() > base) chk("err_rx", got_q[base], 8'h77);
    chk("err_sticky", bus_err, 1);

    // reset in the middle of an ACCESS phase
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (psel && penable) begin ok = 1; break; end
    end
    chk("mid_found", ok, 1);
    rstn = 0; #1;
    chk("mid_psel", psel, 0); chk("mid_penable", penable, 0);
    chk("mid_bus_err", bus_err, 0); chk("mid_cfg_done", cfg_done, 0);
    log_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1;
    wait_cfg("mid_cfg_timeout");
    if (log_q.size() >= 2) begin
      chk("mid_cfg0", log_q[0].addr, 32'h8);
      chk("mid_cfg1", log_q[1].addr, 32'hC);
    end else chk("mid_log", log_q.size(), 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule
